switch_debouncer: RTL and testbench

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

---
 rtl/switch_pkg.sv | 14 +
 rtl/debounce_bit.sv | 57 +++++
 rtl/switch_debouncer.sv | 33 +++
 tb/tb_switch_debouncer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared constants for the switch debouncer and its per-bit slice.
package switch_pkg;

   localparam int SW_WIDTH                = 4;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

   // Stability counter width; never less than one bit so tiny cycle counts still elaborate.
   function automatic int debounce_cnt_w(input int cycles);
      int w;
      w = $clog2(cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One-bit debouncer: 2-flop synchronizer, stability counter, clean level and edge pulses.
module debounce_bit
   import switch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic clean,
   output logic rise,
   output logic fall
);

   localparam int               CNT_W   = debounce_cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   // Bring the asynchronous pin into the clock domain before anything looks at it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Count consecutive clocks of disagreement; accept the new level when the count tops out.
   // Any agreement (a bounce back) clears the count, so it saturates at CNT_MAX by construction.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt   <= '0;
         clean <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (sync2 == clean) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            cnt   <= '0;
            clean <= sync2;
            rise  <= sync2;
            fall  <= ~sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_debouncer.sv
// Multi-bit switch debouncer: one independent debounce_bit slice per switch pin.
module switch_debouncer
   import switch_pkg::*;
#(
   parameter int WIDTH           = SW_WIDTH,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_clean,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             sw_changed
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
         .clk     (clk),
         .reset_n (reset_n),
         .raw     (sw_raw[i]),
         .clean   (sw_clean[i]),
         .rise    (sw_rise[i]),
         .fall    (sw_fall[i])
      );
   end

   // Already-registered pulses are simply ORed so the summary flag lines up with them.
   assign sw_changed = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with a queue-based scoreboard and independent monitor.
module tb_switch_debouncer;

   localparam int W   = 4;
   localparam int N   = 8;
   localparam int LAT = N + 2;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [W-1:0] sw_raw;
   logic [W-1:0] sw_clean;
   logic [W-1:0] sw_rise;
   logic [W-1:0] sw_fall;
   logic         sw_changed;

   typedef struct {
      int           cyc;
      logic [W-1:0] clean;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
   } exp_t;

   exp_t         q[$];
   int           cyc      = 0;
   int           checks   = 0;
   int           failures = 0;
   logic [W-1:0] exp_clean = '0;

   switch_debouncer #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (N)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .sw_raw     (sw_raw),
      .sw_clean   (sw_clean),
      .sw_rise    (sw_rise),
      .sw_fall    (sw_fall),
      .sw_changed (sw_changed)
   );

   always #5 clk = ~clk;

   // Edge index: after rising edge k has occurred, cyc == k.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at edge %0d: got %0h, required %0h", name, cyc, act, req);
      end
   endtask

   // Called just after a negedge drive; first sampling edge is cyc+1, so the result lands on cyc+LAT.
   task automatic expect_evt(input logic [W-1:0] clean, input logic [W-1:0] rise,
                             input logic [W-1:0] fall);
      exp_t e;
      e.cyc   = cyc + LAT;
      e.clean = clean;
      e.rise  = rise;
      e.fall  = fall;
      q.push_back(e);
   endtask

   // Monitor: pops an expectation whenever the DUT reports a change; otherwise checks hold/quiet.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (!reset_n) begin
            check("reset_outputs", int'({sw_clean, sw_rise, sw_fall, sw_changed}), 0);
            exp_clean = '0;
         end else if (sw_changed || (|sw_rise) || (|sw_fall)) begin
            if (q.size() == 0) begin
               check("unexpected_pulse", int'({sw_rise, sw_fall}), 0);
            end else begin
               e = q.pop_front();
               check("event_edge", cyc, e.cyc);
               check("sw_clean",   int'(sw_clean), int'(e.clean));
               check("sw_rise",    int'(sw_rise),  int'(e.rise));
               check("sw_fall",    int'(sw_fall),  int'(e.fall));
               check("sw_changed", int'(sw_changed), 1);
               exp_clean = e.clean;
            end
         end else begin
            check("clean_hold", int'(sw_clean), int'(exp_clean));
            if (q.size() != 0 && q[0].cyc < cyc) begin
               e = q.pop_front();
               check("missed_event_edge", cyc, e.cyc);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic [W-1:0] v);
      @(negedge clk);
      sw_raw = v;
   endtask

   initial begin
      reset_n = 1'b0;
      sw_raw  = '0;
      step(3);
      reset_n = 1'b1;

      // Quiet input after reset: nothing may change for 50 cycles.
      step(50);

      // Bit 0 rises and holds.
      drive(4'b0001);
      expect_evt(4'b0001, 4'b0001, 4'b0000);
      step(20);

      // Bit 1 high for only 7 cycles: must be rejected.
      drive(4'b0011);
      step(7);
      sw_raw = 4'b0001;
      step(20);

      // Bit 2 toggles every 3 cycles for 30 cycles, then settles high.
      for (int ph = 0; ph < 10; ph++) begin
         drive((ph % 2 == 0) ? 4'b0101 : 4'b0001);
         step(2);
      end
      drive(4'b0101);
      expect_evt(4'b0101, 4'b0100, 4'b0000);
      step(20);

      // Move to clean 1000.
      drive(4'b1000);
      expect_evt(4'b1000, 4'b1000, 4'b0101);
      step(20);

      // Simultaneous rise on bit 0 and fall on bit 3.
      drive(4'b0001);
      expect_evt(4'b0001, 4'b0001, 4'b1000);
      step(20);

      // Bit 3 held high, reset while its counter sits at 5 (and bit 0 mid-fall); count is discarded.
      drive(4'b1000);
      step(7);
      reset_n = 1'b0;
      step(3);
      reset_n = 1'b1;
      expect_evt(4'b1000, 4'b1000, 4'b0000);
      step(25);

      check("pending_events", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
